// File: rtl/op_sequencer.sv
// Push-button operand/operation sequencer: debounced press walks IDLE->LOAD_A->LOAD_B->EXEC->SHOW->DONE driving datapath write strobes.
// Optional OP_SEQ_AUTOSCAN_EN: SHOW auto-advances ledsel every SCAN_DIV cycles and any press ends the show.
module op_sequencer #(
    parameter int DEB_CYCLES  = 4,
    parameter int EXEC_CYCLES = 2,
    parameter int SCAN_DIV    = 16
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       next,
    input  logic [2:0] ms,
    input  logic       level,
    output logic [2:0] ms_out,
    output logic       we,
    output logic       w1,
    output logic [1:0] ledsel,
    output logic [3:0] cs,
    output logic       busy,
    output logic       done
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD_A = 4'd1,
        S_LOAD_B = 4'd2,
        S_EXEC   = 4'd3,
        S_SHOW   = 4'd4,
        S_DONE   = 4'd5
    } state_t;

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int EW = $clog2(EXEC_CYCLES + 1);

    if (SCAN_DIV < 1) begin : g_scan_div_chk
        $error("SCAN_DIV must be at least 1");
    end

    logic          sync1_q, sync2_q;
    logic          deb_hi_q, deb_hi_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          press_q, press_d;
    state_t        state_q, state_d;
    logic [2:0]    ms_q, ms_d;
    logic          lvl_q, lvl_d;
    logic          we_q, we_d;
    logic          w1_q, w1_d;
    logic [1:0]    ledsel_q, ledsel_d;
    logic [EW-1:0] exec_cnt_q, exec_cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
`ifdef OP_SEQ_AUTOSCAN_EN
    localparam int SW = $clog2(SCAN_DIV + 1);
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
`endif

    // Debounce: count consecutive samples disagreeing with the debounced level; pulse only on a qualified fall.
    always_comb begin
        deb_cnt_d = '0;
        deb_hi_d  = deb_hi_q;
        press_d   = 1'b0;
        if (sync2_q != deb_hi_q) begin
            if (deb_cnt_q == DW'(DEB_CYCLES - 1)) begin
                deb_hi_d = sync2_q;
                press_d  = ~sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DW'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ms_d       = ms_q;
        lvl_d      = lvl_q;
        we_d       = 1'b0;
        w1_d       = w1_q;
        ledsel_d   = ledsel_q;
        exec_cnt_d = exec_cnt_q;
`ifdef OP_SEQ_AUTOSCAN_EN
        scan_cnt_d = scan_cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (press_q) begin
                    state_d = S_LOAD_A;
                    ms_d    = ms;
                    lvl_d   = level;
                end
            end
            S_LOAD_A: begin
                if (press_q) begin
                    we_d       = 1'b1;
                    w1_d       = 1'b0;
                    exec_cnt_d = '0;
                    state_d    = lvl_q ? S_EXEC : S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                if (press_q) begin
                    we_d       = 1'b1;
                    w1_d       = 1'b1;
                    exec_cnt_d = '0;
                    state_d    = S_EXEC;
                end
            end
            S_EXEC: begin
                // Presses arriving here are dropped: nothing latches press_q.
                if (exec_cnt_q == EW'(EXEC_CYCLES - 1)) begin
                    state_d  = S_SHOW;
                    ledsel_d = 2'd0;
`ifdef OP_SEQ_AUTOSCAN_EN
                    scan_cnt_d = '0;
`endif
                end else begin
                    exec_cnt_d = exec_cnt_q + EW'(1);
                end
            end
            S_SHOW: begin
`ifdef OP_SEQ_AUTOSCAN_EN
                if (press_q) begin
                    state_d = S_DONE;
                end else if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
                    scan_cnt_d = '0;
                    ledsel_d   = ledsel_q + 2'd1;
                end else begin
                    scan_cnt_d = scan_cnt_q + SW'(1);
                end
`else
                if (press_q) begin
                    if (ledsel_q != 2'd3) begin
                        ledsel_d = ledsel_q + 2'd1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
`endif
            end
            S_DONE: begin
                if (press_q) begin
                    state_d  = S_IDLE;
                    ledsel_d = 2'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_EXEC);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            deb_hi_q   <= 1'b1;
            deb_cnt_q  <= '0;
            press_q    <= 1'b0;
            state_q    <= S_IDLE;
            ms_q       <= 3'd0;
            lvl_q      <= 1'b0;
            we_q       <= 1'b0;
            w1_q       <= 1'b0;
            ledsel_q   <= 2'd0;
            exec_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef OP_SEQ_AUTOSCAN_EN
            scan_cnt_q <= '0;
`endif
        end else begin
            sync1_q    <= next;
            sync2_q    <= sync1_q;
            deb_hi_q   <= deb_hi_d;
            deb_cnt_q  <= deb_cnt_d;
            press_q    <= press_d;
            state_q    <= state_d;
            ms_q       <= ms_d;
            lvl_q      <= lvl_d;
            we_q       <= we_d;
            w1_q       <= w1_d;
            ledsel_q   <= ledsel_d;
            exec_cnt_q <= exec_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef OP_SEQ_AUTOSCAN_EN
            scan_cnt_q <= scan_cnt_d;
`endif
        end
    end

    assign ms_out = ms_q;
    assign we     = we_q;
    assign w1     = w1_q;
    assign ledsel = ledsel_q;
    assign cs     = state_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
